// File: rtl/channel_router_if.sv
// Bus bundle for channel_router: load/select/mode controls in, channel and readback outputs back.
// The clr control exists only when CHANNEL_CLEAR_EN is defined.
interface channel_router_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
);
    logic [WIDTH-1:0]          data_in;
    logic [SEL_W-1:0]          sel;
    logic                      load;
    logic                      mode;
`ifdef CHANNEL_CLEAR_EN
    logic                      clr;
`endif
    logic [CHANNELS*WIDTH-1:0] ch_out;
    logic [WIDTH-1:0]          mux_out;
    logic [SEL_W-1:0]          cur_sel;
    logic                      scan_wrap;

    modport master (
`ifdef CHANNEL_CLEAR_EN
        output clr,
`endif
        output data_in, sel, load, mode,
        input  ch_out, mux_out, cur_sel, scan_wrap
    );

    modport slave (
`ifdef CHANNEL_CLEAR_EN
        input  clr,
`endif
        input  data_in, sel, load, mode,
        output ch_out, mux_out, cur_sel, scan_wrap
    );
endinterface

// File: rtl/channel_router.sv
// Registered demux into CHANNELS holding registers with a manual/scan readback mux.
// Optional feature: define CHANNEL_CLEAR_EN to add the clr input that zeroes all channels.
module channel_router #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    channel_router_if.slave  bus
);
    localparam int unsigned        PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]      PLAST = PW'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]   LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]     NCH   = (SEL_W + 1)'(CHANNELS);

    typedef enum logic {
        MANUAL,
        SCAN
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
    logic              wrap_q, wrap_d;
    logic [WIDTH-1:0]  mux_q, mux_d;
    logic [WIDTH-1:0]  ch_q [CHANNELS];
    logic              sel_ok;

    assign sel_ok = ({1'b0, bus.sel} < NCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MANUAL;
            presc_q   <= '0;
            cur_sel_q <= '0;
            wrap_q    <= 1'b0;
            mux_q     <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cur_sel_q <= cur_sel_d;
            wrap_q    <= wrap_d;
            mux_q     <= mux_d;
        end
    end

    // Channel storage; clr (when built in) beats a simultaneous load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < CHANNELS; k++) ch_q[k] <= '0;
`ifdef CHANNEL_CLEAR_EN
        end else if (bus.clr) begin
            for (int unsigned k = 0; k < CHANNELS; k++) ch_q[k] <= '0;
`endif
        end else if (bus.load && sel_ok) begin
            ch_q[bus.sel] <= bus.data_in;
        end
    end

    // Mode-change edges only switch state and clear the prescaler; the pointer holds there.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cur_sel_d = cur_sel_q;
        wrap_d    = 1'b0;
        case (state_q)
            MANUAL: begin
                if (bus.mode) begin
                    state_d = SCAN;
                    presc_d = '0;
                end else if (sel_ok) begin
                    cur_sel_d = bus.sel;
                end
            end
            SCAN: begin
                if (!bus.mode) begin
                    state_d = MANUAL;
                    presc_d = '0;
                end else if (presc_q == PLAST) begin
                    presc_d = '0;
                    if (cur_sel_q == LAST) begin
                        cur_sel_d = '0;
                        wrap_d    = 1'b1;
                    end else begin
                        cur_sel_d = cur_sel_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = MANUAL;
        endcase

        // Reads the pre-edge channel contents, so a same-edge load shows up a cycle later.
        mux_d = '0;
        if ({1'b0, cur_sel_d} < NCH) mux_d = ch_q[cur_sel_d];
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch_out
        assign bus.ch_out[k*WIDTH +: WIDTH] = ch_q[k];
    end

    assign bus.mux_out   = mux_q;
    assign bus.cur_sel   = cur_sel_q;
    assign bus.scan_wrap = wrap_q;
endmodule

// File: doc/channel_router.md
# channel_router

Registered, parametrised successor to the week-6 switch-driven mux/demux datapath. A WIDTH-bit input word is demultiplexed into one of CHANNELS holding registers on a load strobe. A registered multiplexer reads one channel back, either the one named by the select input (manual mode) or one chosen by an internal prescaled scan pointer that rotates through all channels (scan mode). The block sits between the switch/button input logic and the LED/display drivers of the board top level.

## Interface

Parameters:
- WIDTH, 8, data word width in bits (≥1)
- CHANNELS, 4, number of holding registers (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ CHANNELS
- SCAN_DIV, 4, clock cycles per scan step (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- data_in  input  WIDTH  word to store
- sel  input  SEL_W  load target, and readback channel in manual mode
- load  input  1  write strobe, sampled each cycle
- mode  input  1  0 = manual readback, 1 = scan readback
- ch_out  output  CHANNELS*WIDTH  all holding registers; channel k at bits [k*WIDTH +: WIDTH]
- mux_out  output  WIDTH  registered readback of channel cur_sel
- cur_sel  output  SEL_W  channel currently driving mux_out
- scan_wrap  output  1  one-cycle pulse when the scan pointer wraps to 0
- clr  input  1  present only with CHANNEL_CLEAR_EN (see Configuration)

## Operation

- All outputs are registered. Reset values: ch_out = 0, mux_out = 0, cur_sel = 0, scan_wrap = 0. The internal state is MANUAL and the prescaler is 0.
- Load: if load = 1 and sel < CHANNELS, channel[sel] ← data_in at the clock edge. If sel ≥ CHANNELS, the load is ignored and no register changes.
- Load applies in both modes. The load target is always sel, never the scan pointer.
- State machine has two states, MANUAL and SCAN:
  - MANUAL → SCAN when mode = 1. The prescaler clears to 0 and the pointer continues from the current cur_sel.
  - SCAN → MANUAL when mode = 0. The prescaler clears to 0.
- MANUAL: cur_sel ← sel each cycle. If sel ≥ CHANNELS, cur_sel holds its previous value.
- SCAN:
  - The prescaler counts 0..SCAN_DIV-1.
  - When it reaches SCAN_DIV-1 it returns to 0 and cur_sel advances by 1.
  - After CHANNELS-1, cur_sel wraps to 0 and scan_wrap = 1 for exactly that cycle.
  - scan_wrap is 0 at all other times and always 0 in MANUAL.
- mux_out ← channel[cur_sel_next], where cur_sel_next is the value cur_sel takes at the same edge.
- Read-before-write: if a load targets the channel being read on the same edge, mux_out shows the old contents. The new value appears one cycle later.
- No arithmetic overflow is possible. Pointer and prescaler wrap exactly as described, with no saturation.

## Timing

- Load to ch_out: 1 cycle. Load to mux_out when the same channel is selected: 2 cycles.
- Manual sel change to cur_sel and mux_out: 1 cycle, both updated on the same edge.
- In SCAN, cur_sel dwells on each channel for exactly SCAN_DIV cycles. A full rotation takes CHANNELS*SCAN_DIV cycles.
- First step after entering SCAN: SCAN_DIV cycles after the edge that registered the mode change.
- Reset asserted mid-operation has priority over every other input, including load and clr. All state returns to reset values on the next edge.

## Configuration

- CHANNEL_CLEAR_EN defined:
  - Adds input clr (1 bit).
  - clr = 1 zeroes all channel registers at the next edge. It overrides a simultaneous load.
  - mux_out reads 0 one cycle later.
  - cur_sel, state and prescaler are unaffected.
- CHANNEL_CLEAR_EN undefined: the clr port and its logic are absent. Channels clear only on reset.

## Test plan

All scenarios use WIDTH=8, CHANNELS=4, SEL_W=2, SCAN_DIV=4.
- Reset: hold reset 2 cycles with load=1, data_in=8'hFF → ch_out=0, mux_out=0, cur_sel=0, scan_wrap=0 throughout.
- Demux/manual mux: load 8'h11, 8'h22, 8'h33, 8'h44 into sel 0..3. Then mode=0, sel=2 → ch_out=32'h44332211; mux_out=8'h33 one cycle after sel=2.
- Scan: mode=1 → cur_sel steps 0→1→2→3→0 every 4 cycles; mux_out follows 11,22,33,44,11; scan_wrap pulses once per 16 cycles on the 3→0 edge.
- Read-before-write: in manual mode with sel=1, load data_in=8'hA5 → mux_out=8'h22 on the load edge, 8'hA5 one cycle later.
- Mid-scan reset: assert reset while cur_sel=2 in SCAN → next edge gives cur_sel=0, all channels 0. After release, stays MANUAL until mode is sampled.
- With CHANNEL_CLEAR_EN: clr=1 together with load=1, sel=0, data_in=8'h77 → ch_out=0 next edge; mux_out=0 the following edge.
